// File: rtl/mvu_inp_replay_buffer.sv
// mvu_inp_replay_buffer
// Streaming input-vector buffer for the MVU datapath. The first pass of each
// vector is forwarded straight from the input stream while being stored; the
// stored vector is then replayed NF-1 more times, once per neuron fold.
// Optional performance counters are compiled in with MVU_INP_BUF_PERF_EN.
//
// state  | meaning
// FILL   | pass 0: accept input words, store and forward them
// REPLAY | passes 1..NF-1: re-issue stored words, input stalled

module mvu_inp_replay_buffer #(
    parameter int SIMD  = 2,
    parameter int TSrcI = 4,
    parameter int SF    = 8,
    parameter int NF    = 4,
    parameter int SF_W  = (SF > 1) ? $clog2(SF) : 1,
    parameter int NF_W  = (NF > 1) ? $clog2(NF) : 1
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [SIMD*TSrcI-1:0]   in_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [SIMD*TSrcI-1:0]   out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [SF_W-1:0]         out_sf,
    output logic [NF_W-1:0]         out_nf,
`ifdef MVU_INP_BUF_PERF_EN
    output logic [31:0]             vec_count,
    output logic [31:0]             in_stall_count,
    output logic [31:0]             out_stall_count,
`endif
    output logic                    out_last
);

    localparam int W = SIMD * TSrcI;
    localparam logic [SF_W-1:0] SF_LAST = SF_W'(SF - 1);
    localparam logic [NF_W-1:0] NF_LAST = NF_W'(NF - 1);
    // With a single neuron fold the block degenerates to a registered stage.
    localparam bit MULTI_PASS = (NF > 1);

    typedef enum logic {
        FILL   = 1'b0,
        REPLAY = 1'b1
    } state_t;

    state_t state, state_nxt;

    logic [W-1:0]    mem [SF];
    logic [SF_W-1:0] wr_ptr;
    logic [SF_W-1:0] rd_ptr;
    logic [NF_W-1:0] nf_cnt;

    logic adv;
    logic accept;
    logic rd_load;
    logic wr_wrap;
    logic rd_wrap;
    logic rd_done;

    assign adv     = !out_valid || out_ready;
    assign accept  = in_valid && in_ready;
    assign wr_wrap = (wr_ptr == SF_LAST);
    assign rd_wrap = (rd_ptr == SF_LAST);
    assign rd_done = rd_wrap && (nf_cnt == NF_LAST);

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= FILL;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and handshake decode; in_ready is held low during reset.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        rd_load   = 1'b0;
        case (state)
            FILL: begin
                in_ready = adv && !reset;
                if (in_valid && in_ready && wr_wrap && MULTI_PASS) begin
                    state_nxt = REPLAY;
                end
            end
            REPLAY: begin
                rd_load = adv;
                if (adv && rd_done) begin
                    state_nxt = FILL;
                end
            end
            default: begin
                state_nxt = FILL;
            end
        endcase
    end

    // Vector storage; written only during pass 0, so it never collides with replay reads.
    always_ff @(posedge clock) begin
        if (accept) begin
            mem[wr_ptr] <= in_data;
        end
    end

    // Write pointer, replay pointer and fold counter.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            nf_cnt <= '0;
        end else begin
            if (accept) begin
                wr_ptr <= wr_wrap ? '0 : wr_ptr + 1'b1;
                if (wr_wrap && MULTI_PASS) begin
                    rd_ptr <= '0;
                    nf_cnt <= NF_W'(1);
                end
            end
            if (rd_load) begin
                rd_ptr <= rd_wrap ? '0 : rd_ptr + 1'b1;
                if (rd_done) begin
                    nf_cnt <= '0;
                end else if (rd_wrap) begin
                    nf_cnt <= nf_cnt + 1'b1;
                end
            end
        end
    end

    // Output register: loads the live input in FILL or a stored word in REPLAY, holds while stalled.
    always_ff @(posedge clock) begin
        if (reset) begin
            out_data  <= '0;
            out_valid <= 1'b0;
            out_sf    <= '0;
            out_nf    <= '0;
            out_last  <= 1'b0;
        end else if (accept) begin
            out_data  <= in_data;
            out_valid <= 1'b1;
            out_sf    <= wr_ptr;
            out_nf    <= '0;
            out_last  <= !MULTI_PASS && wr_wrap;
        end else if (rd_load) begin
            out_data  <= mem[rd_ptr];
            out_valid <= 1'b1;
            out_sf    <= rd_ptr;
            out_nf    <= nf_cnt;
            out_last  <= rd_done;
        end else if (adv) begin
            out_valid <= 1'b0;
        end
    end

`ifdef MVU_INP_BUF_PERF_EN
    // Saturating event counters; observation only, no effect on the datapath.
    always_ff @(posedge clock) begin
        if (reset) begin
            vec_count       <= '0;
            in_stall_count  <= '0;
            out_stall_count <= '0;
        end else begin
            if (out_valid && out_ready && out_last && (vec_count != '1)) begin
                vec_count <= vec_count + 1'b1;
            end
            if (in_valid && !in_ready && (in_stall_count != '1)) begin
                in_stall_count <= in_stall_count + 1'b1;
            end
            if (out_valid && !out_ready && (out_stall_count != '1)) begin
                out_stall_count <= out_stall_count + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mvu_inp_replay_buffer.sv
// Bench for mvu_inp_replay_buffer: a 4x3-fold instance checked against a
// scoreboard of expected output words, plus a 1x1-fold pass-through instance.
module tb_mvu_inp_replay_buffer;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic       reset;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic [1:0] out_sf;
    logic [1:0] out_nf;
    logic       out_last;

    logic [7:0] in1_data;
    logic       in1_valid;
    logic       in1_ready;
    logic [7:0] out1_data;
    logic       out1_valid;
    logic       out1_ready;
    logic [0:0] out1_sf;
    logic [0:0] out1_nf;
    logic       out1_last;

`ifdef MVU_INP_BUF_PERF_EN
    logic [31:0] vec_count, in_stall_count, out_stall_count;
    logic [31:0] vec_count1, in_stall_count1, out_stall_count1;
`endif

    mvu_inp_replay_buffer #(.SIMD(2), .TSrcI(4), .SF(4), .NF(3)) dut (
        .clock(clock), .reset(reset),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_sf(out_sf), .out_nf(out_nf),
`ifdef MVU_INP_BUF_PERF_EN
        .vec_count(vec_count), .in_stall_count(in_stall_count),
        .out_stall_count(out_stall_count),
`endif
        .out_last(out_last)
    );

    mvu_inp_replay_buffer #(.SIMD(2), .TSrcI(4), .SF(1), .NF(1)) dut1 (
        .clock(clock), .reset(reset),
        .in_data(in1_data), .in_valid(in1_valid), .in_ready(in1_ready),
        .out_data(out1_data), .out_valid(out1_valid), .out_ready(out1_ready),
        .out_sf(out1_sf), .out_nf(out1_nf),
`ifdef MVU_INP_BUF_PERF_EN
        .vec_count(vec_count1), .in_stall_count(in_stall_count1),
        .out_stall_count(out_stall_count1),
`endif
        .out_last(out1_last)
    );

    typedef struct packed {
        logic [7:0] data;
        logic [1:0] sf;
        logic [1:0] nf;
        logic       last;
    } exp_t;

    int   checks   = 0;
    int   failures = 0;
    exp_t q[$];
    logic [7:0] m_mem [4];
    int   m_wr = 0;

    task automatic step;
        @(posedge clock);
        #1;
    endtask

    // Scoreboard sampling at the falling edge: pop on output transfer, push on input accept.
    task automatic sb_sample;
        exp_t e;
        if (reset) begin
            q.delete();
            m_wr = 0;
        end else begin
            if (out_valid && out_ready) begin
                checks++;
                if (q.size() == 0) begin
                    failures++;
                    $display("FAIL sb_unexpected actual data=%h sf=%0d nf=%0d last=%0d required=no word",
                             out_data, out_sf, out_nf, out_last);
                end else begin
                    e = q.pop_front();
                    if ({out_data, out_sf, out_nf, out_last} !== e) begin
                        failures++;
                        $display("FAIL sb_word actual data=%h sf=%0d nf=%0d last=%0d required data=%h sf=%0d nf=%0d last=%0d",
                                 out_data, out_sf, out_nf, out_last, e.data, e.sf, e.nf, e.last);
                    end
                end
            end
            if (in_valid && in_ready) begin
                m_mem[m_wr] = in_data;
                q.push_back('{in_data, 2'(m_wr), 2'd0, 1'b0});
                if (m_wr == 3) begin
                    for (int p = 1; p < 3; p++)
                        for (int s = 0; s < 4; s++)
                            q.push_back('{m_mem[s], 2'(s), 2'(p), (p == 2 && s == 3)});
                    m_wr = 0;
                end else begin
                    m_wr++;
                end
            end
        end
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (q.size() != 0 && n < 200) begin
            step;
            n++;
        end
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL %s_drain actual pending=%0d required=0", name, q.size());
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; in_valid = 1'b1; in_data = 8'h00; out_ready = 1'b1;
        in1_valid = 1'b1; in1_data = 8'h00; out1_ready = 1'b1;
        step; step;
        checks++;
        if (in_ready !== 1'b0) begin failures++; $display("FAIL rst_in_ready actual=%b required=0", in_ready); end
        checks++;
        if (in1_ready !== 1'b0) begin failures++; $display("FAIL rst_in1_ready actual=%b required=0", in1_ready); end
        checks++;
        if ({out_valid, out_data, out_sf, out_nf, out_last} !== 13'd0) begin
            failures++;
            $display("FAIL rst_outputs actual valid=%b data=%h sf=%0d nf=%0d last=%b required all zero",
                     out_valid, out_data, out_sf, out_nf, out_last);
        end
        in_valid = 1'b0; in1_valid = 1'b0; reset = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_release_in_ready actual=%b required=1", in_ready); end
    endtask

    task automatic test_single_vector;
        logic [7:0] v [4];
        v = '{8'h11, 8'h22, 8'h33, 8'h44};
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_data = v[i];
            checks++;
            if (in_ready !== 1'b1) begin failures++; $display("FAIL single_fill_ready word=%0d actual=%b required=1", i, in_ready); end
            step;
        end
        in_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
                failures++;
                $display("FAIL single_replay_cycle k=%0d actual valid=%b in_ready=%b required valid=1 in_ready=0",
                         k, out_valid, in_ready);
            end
            step;
        end
        checks++;
        if (out_valid !== 1'b1 || out_last !== 1'b1 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL single_last_word actual valid=%b last=%b in_ready=%b required 1 1 1",
                     out_valid, out_last, in_ready);
        end
        step;
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL single_idle actual valid=%b required=0", out_valid); end
        drain("single");
    endtask

    task automatic test_back_to_back;
        logic [7:0] v [8];
        int waited;
        v = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h55, 8'h66, 8'h77, 8'h88};
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1; in_data = v[i];
            waited = 0;
            while (!in_ready && waited < 50) begin
                step;
                waited++;
            end
            if (i == 4) begin
                checks++;
                if (waited != 8) begin failures++; $display("FAIL b2b_ready_rise actual wait=%0d required=8", waited); end
                checks++;
                if (out_valid !== 1'b1 || out_last !== 1'b1) begin
                    failures++;
                    $display("FAIL b2b_last_shown actual valid=%b last=%b required 1 1", out_valid, out_last);
                end
            end
            step;
            if (i == 4) begin
                checks++;
                if (out_valid !== 1'b1 || out_data !== 8'h55 || out_nf !== 2'd0 || out_sf !== 2'd0) begin
                    failures++;
                    $display("FAIL b2b_first_word actual valid=%b data=%h sf=%0d nf=%0d required 1 55 0 0",
                             out_valid, out_data, out_sf, out_nf);
                end
            end
        end
        in_valid = 1'b0;
        drain("b2b");
        step;
    endtask

    task automatic test_stall;
        logic [7:0] v [4];
        logic       pat [4];
        logic [13:0] snap;
        logic       stalled_prev;
        int         n;
        v = '{8'hC1, 8'hC2, 8'hC3, 8'hC4};
        pat = '{1'b1, 1'b0, 1'b0, 1'b1};
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_data = v[i];
            step;
        end
        in_valid = 1'b0;
        n = 0;
        stalled_prev = 1'b0;
        snap = '0;
        while (q.size() != 0 && n < 100) begin
            if (stalled_prev) begin
                checks++;
                if ({out_valid, out_data, out_sf, out_nf, out_last} !== snap) begin
                    failures++;
                    $display("FAIL stall_hold cycle=%0d actual=%h required=%h", n,
                             {out_valid, out_data, out_sf, out_nf, out_last}, snap);
                end
            end
            out_ready = pat[n % 4];
            snap = {out_valid, out_data, out_sf, out_nf, out_last};
            stalled_prev = out_valid && !out_ready;
            step;
            n++;
        end
        checks++;
        if (q.size() != 0) begin failures++; $display("FAIL stall_timeout actual pending=%0d required=0", q.size()); end
        out_ready = 1'b1;
        step;
    endtask

    task automatic test_reset_midstream;
        logic [7:0] v [4];
        v = '{8'h31, 8'h32, 8'h33, 8'h34};
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_data = v[i];
            step;
        end
        in_valid = 1'b0;
        step; step;
        checks++;
        if (out_nf !== 2'd1 || out_sf !== 2'd1) begin
            failures++;
            $display("FAIL mid_sixth_word actual sf=%0d nf=%0d required sf=1 nf=1", out_sf, out_nf);
        end
        reset = 1'b1;
        step;
        reset = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL mid_after_reset actual valid=%b in_ready=%b required valid=0 in_ready=1", out_valid, in_ready);
        end
        step;
        v = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_data = v[i];
            step;
        end
        in_valid = 1'b0;
        drain("mid");
        step;
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL mid_stale actual valid=%b required=0", out_valid); end
    endtask

    task automatic test_passthrough;
        logic [7:0] q1[$];
        logic [7:0] e;
        out1_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in1_valid = 1'b1;
            in1_data  = 8'(8'hD0 + i);
            q1.push_back(in1_data);
            checks++;
            if (in1_ready !== 1'b1) begin failures++; $display("FAIL pt_ready word=%0d actual=%b required=1", i, in1_ready); end
            step;
            e = q1.pop_front();
            checks++;
            if (out1_valid !== 1'b1 || out1_data !== e || out1_last !== 1'b1 || out1_sf !== 1'b0 || out1_nf !== 1'b0) begin
                failures++;
                $display("FAIL pt_word word=%0d actual valid=%b data=%h last=%b sf=%0d nf=%0d required valid=1 data=%h last=1 sf=0 nf=0",
                         i, out1_valid, out1_data, out1_last, out1_sf, out1_nf, e);
            end
        end
        in1_valid = 1'b0;
        step;
        checks++;
        if (out1_valid !== 1'b0) begin failures++; $display("FAIL pt_idle actual valid=%b required=0", out1_valid); end
    endtask

`ifdef MVU_INP_BUF_PERF_EN
    task automatic test_perf;
        logic [7:0] v [4];
        int n;
        v = '{8'h11, 8'h22, 8'h33, 8'h44};
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        step; step;
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_data = v[i];
            step;
        end
        in_valid = 1'b0;
        n = 0;
        while (out_last !== 1'b1 && n < 50) begin
            step;
            n++;
        end
        out_ready = 1'b0;
        step; step; step;
        out_ready = 1'b1;
        step;
        checks++;
        if (vec_count !== 32'd1 || out_stall_count !== 32'd3 || in_stall_count !== 32'd0) begin
            failures++;
            $display("FAIL perf_counts actual vec=%0d out_stall=%0d in_stall=%0d required 1 3 0",
                     vec_count, out_stall_count, in_stall_count);
        end
        drain("perf");
    endtask
`endif

    initial begin
        fork
            forever begin
                @(negedge clock);
                sb_sample();
            end
        join_none
        test_reset();
        test_single_vector();
        test_back_to_back();
        test_stall();
        test_reset_midstream();
        test_passthrough();
`ifdef MVU_INP_BUF_PERF_EN
        test_perf();
`endif
        checks++;
        if (q.size() != 0) begin failures++; $display("FAIL sb_leftover actual pending=%0d required=0", q.size()); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
